// File: rtl/argmax_unit_if.sv
// Handshake and result bundle for argmax_unit.
// ARGMAX_TOP2_EN adds the runner-up index and the winning margin.
interface argmax_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 4
);
    logic                  start;
    logic                  score_valid;
    logic [DATA_WIDTH-1:0] score_data;
    logic                  score_ready;
    logic                  busy;
    logic                  done;
    logic [IDX_WIDTH-1:0]  argmax_output;
    logic [DATA_WIDTH-1:0] max_value;
`ifdef ARGMAX_TOP2_EN
    logic [IDX_WIDTH-1:0]  runner_up_idx;
    logic [DATA_WIDTH:0]   margin;
`endif

    modport master (
        output start,
        output score_valid,
        output score_data,
        input  score_ready,
        input  busy,
        input  done,
        input  argmax_output,
        input  max_value
`ifdef ARGMAX_TOP2_EN
        ,
        input  runner_up_idx,
        input  margin
`endif
    );

    modport slave (
        input  start,
        input  score_valid,
        input  score_data,
        output score_ready,
        output busy,
        output done,
        output argmax_output,
        output max_value
`ifdef ARGMAX_TOP2_EN
        ,
        output runner_up_idx,
        output margin
`endif
    );
endinterface

// File: rtl/argmax_unit.sv
// Streaming argmax over NUM_CLASSES signed scores.
// Optional ARGMAX_TOP2_EN also tracks runner-up index and margin.
module argmax_unit #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int IDX_WIDTH   = 4
) (
    input logic           clk,
    input logic           reset,
    argmax_unit_if.slave  bus
);
    localparam int CW = IDX_WIDTH + 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] run_max;
    logic [IDX_WIDTH-1:0]  run_idx;
    logic [IDX_WIDTH-1:0]  res_idx;
    logic [DATA_WIDTH-1:0] res_max;

    logic                  accept;
    logic                  first;
    logic                  last;
    logic                  greater;
    logic                  take;
    logic [IDX_WIDTH-1:0]  cidx;
    logic [DATA_WIDTH-1:0] max_nxt;
    logic [IDX_WIDTH-1:0]  idx_nxt;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; start is ignored while scanning
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.start) state_nxt = SCAN;
            SCAN: if (accept && last) state_nxt = DONE;
            DONE: if (bus.start) state_nxt = SCAN;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs decoded from state
    always_comb begin
        bus.score_ready = 1'b0;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        unique case (state)
            SCAN: begin
                bus.score_ready = 1'b1;
                bus.busy        = 1'b1;
            end
            DONE: bus.done = 1'b1;
            default: ;
        endcase
    end

    // Candidate winner including the score on the bus this cycle
    always_comb begin
        accept  = bus.score_valid && (state == SCAN);
        first   = (count == '0);
        last    = (count == LAST);
        cidx    = count[IDX_WIDTH-1:0];
        greater = $signed(bus.score_data) > $signed(run_max);
        take    = first || greater;
        max_nxt = take ? bus.score_data : run_max;
        idx_nxt = take ? cidx : run_idx;
    end

    // Running max, scan counter and published result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            run_max <= '0;
            run_idx <= '0;
            res_idx <= '1;
            res_max <= '0;
        end else if (accept) begin
            count   <= count + 1'b1;
            run_max <= max_nxt;
            run_idx <= idx_nxt;
            if (last) begin
                res_idx <= idx_nxt;
                res_max <= max_nxt;
            end
        end else if (state != SCAN && bus.start) begin
            count <= '0;
        end
    end

    assign bus.argmax_output = res_idx;
    assign bus.max_value     = res_max;

`ifdef ARGMAX_TOP2_EN
    logic [DATA_WIDTH-1:0] run_r2;
    logic [IDX_WIDTH-1:0]  run_r2_idx;
    logic [DATA_WIDTH-1:0] r2_nxt;
    logic [IDX_WIDTH-1:0]  r2_idx_nxt;
    logic [DATA_WIDTH:0]   diff;
    logic [IDX_WIDTH-1:0]  res_r2_idx;
    logic [DATA_WIDTH:0]   res_margin;

    // Runner-up: demoted max, or a score beating the current runner-up
    always_comb begin
        r2_nxt     = run_r2;
        r2_idx_nxt = run_r2_idx;
        if (!first) begin
            if (greater) begin
                r2_nxt     = run_max;
                r2_idx_nxt = run_idx;
            end else if (count == CW'(1) ||
                         $signed(bus.score_data) > $signed(run_r2)) begin
                r2_nxt     = bus.score_data;
                r2_idx_nxt = cidx;
            end
        end
        diff = {max_nxt[DATA_WIDTH-1], max_nxt} -
               {r2_nxt[DATA_WIDTH-1], r2_nxt};
    end

    // Runner-up tracking and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_r2     <= '0;
            run_r2_idx <= '0;
            res_r2_idx <= '1;
            res_margin <= '0;
        end else if (accept) begin
            run_r2     <= r2_nxt;
            run_r2_idx <= r2_idx_nxt;
            if (last) begin
                res_r2_idx <= r2_idx_nxt;
                res_margin <= diff;
            end
        end
    end

    assign bus.runner_up_idx = res_r2_idx;
    assign bus.margin        = res_margin;
`endif
endmodule

// File: tb/tb_argmax_unit.sv
// Directed self-checking bench for argmax_unit.
// Top-2 checks are compiled in with ARGMAX_TOP2_EN.
module tb_argmax_unit;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    argmax_unit_if bus ();

    argmax_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int errors   = 0;
    int timeouts = 0;
    int hs_mon   = 0;
    bit gaps     = 0;
    logic [31:0] vec [10];

    // Count real handshakes seen at the DUT boundary
    always @(posedge clk) begin
        if (bus.score_valid && bus.score_ready)
            hs_mon <= hs_mon + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d);
        bit got;
        got = 0;
        bus.score_valid = 1'b1;
        bus.score_data  = d;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clk);
            if (bus.score_ready) got = 1;
        end
        #1;
        if (!got) timeouts++;
    endtask

    task automatic stream(input int n);
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 3);
                for (int j = 0; j < g; j++) begin
                    bus.score_valid = 1'b0;
                    bus.start       = 1'b1;
                    tick();
                    bus.start = 1'b0;
                end
            end
            send(vec[k]);
        end
    endtask

    task automatic load_basic;
        vec[0] = 32'd5;  vec[1] = -32'sd3; vec[2] = 32'd12;
        vec[3] = 32'd7;  vec[4] = 32'd0;   vec[5] = 32'd1;
        vec[6] = 32'd2;  vec[7] = 32'd3;   vec[8] = 32'd4;
        vec[9] = 32'd11;
    endtask

    task automatic test_reset;
        bus.start       = 1'b0;
        bus.score_valid = 1'b0;
        bus.score_data  = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (bus.score_ready !== 1'b0 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL idle_hold ready=%b done=%b want 0 0",
                         bus.score_ready, bus.done);
            end
        end
        checks++;
        if (bus.argmax_output !== 4'hF) begin
            errors++;
            $display("FAIL reset_idx got %h want f", bus.argmax_output);
        end
        checks++;
        if (bus.max_value !== 32'd0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_max got %h busy=%b want 0 0",
                     bus.max_value, bus.busy);
        end
`ifdef ARGMAX_TOP2_EN
        checks++;
        if (bus.runner_up_idx !== 4'hF || bus.margin !== 33'd0) begin
            errors++;
            $display("FAIL reset_top2 got %h %h want f 0",
                     bus.runner_up_idx, bus.margin);
        end
`endif
    endtask

    task automatic test_basic;
        load_basic();
        gaps = 0;
        pulse_start();
        checks++;
        if (bus.busy !== 1'b1 || bus.score_ready !== 1'b1) begin
            errors++;
            $display("FAIL scan_flags busy=%b ready=%b want 1 1",
                     bus.busy, bus.score_ready);
        end
        stream(9);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_done got %b want 0", bus.done);
        end
        send(vec[9]);
        bus.score_valid = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.score_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_done done=%b ready=%b want 1 0",
                     bus.done, bus.score_ready);
        end
        checks++;
        if (bus.argmax_output !== 4'd2 || bus.max_value !== 32'd12) begin
            errors++;
            $display("FAIL basic_result got %0d/%0d want 2/12",
                     bus.argmax_output, bus.max_value);
        end
        tick();
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.argmax_output !== 4'd2) begin
            errors++;
            $display("FAIL basic_hold done=%b idx=%0d want 1 2",
                     bus.done, bus.argmax_output);
        end
    endtask

    task automatic test_min_ties;
        for (int i = 0; i < 10; i++) vec[i] = 32'h8000_0000;
        pulse_start();
        checks++;
        if (bus.done !== 1'b0 || bus.argmax_output !== 4'd2) begin
            errors++;
            $display("FAIL restart_keep done=%b idx=%0d want 0 2",
                     bus.done, bus.argmax_output);
        end
        stream(10);
        bus.score_valid = 1'b0;
        checks++;
        if (bus.argmax_output !== 4'd0 ||
            bus.max_value !== 32'h8000_0000) begin
            errors++;
            $display("FAIL min_result got %0d/%h want 0/80000000",
                     bus.argmax_output, bus.max_value);
        end
        for (int i = 0; i < 10; i++) vec[i] = 32'd9;
        pulse_start();
        stream(10);
        bus.score_valid = 1'b0;
        checks++;
        if (bus.argmax_output !== 4'd0 || bus.max_value !== 32'd9) begin
            errors++;
            $display("FAIL ties_result got %0d/%0d want 0/9",
                     bus.argmax_output, bus.max_value);
        end
    endtask

    task automatic test_gaps_start;
        int base;
        for (int i = 0; i < 9; i++) vec[i] = i;
        vec[9] = 32'd100;
        pulse_start();
        base = hs_mon;
        gaps = 1;
        stream(9);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL gaps_early done=%b busy=%b want 0 1",
                     bus.done, bus.busy);
        end
        send(vec[9]);
        bus.score_valid = 1'b0;
        gaps = 0;
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL gaps_done got %b want 1", bus.done);
        end
        checks++;
        if (bus.argmax_output !== 4'd9 || bus.max_value !== 32'd100) begin
            errors++;
            $display("FAIL gaps_result got %0d/%0d want 9/100",
                     bus.argmax_output, bus.max_value);
        end
        checks++;
        if (hs_mon - base !== 10) begin
            errors++;
            $display("FAIL gaps_handshakes got %0d want 10", hs_mon - base);
        end
    endtask

    task automatic test_reset_mid;
        load_basic();
        pulse_start();
        stream(10);
        bus.score_valid = 1'b0;
        checks++;
        if (bus.argmax_output !== 4'd2) begin
            errors++;
            $display("FAIL pre_abort got %0d want 2", bus.argmax_output);
        end
        pulse_start();
        stream(4);
        bus.score_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.argmax_output !== 4'hF || bus.max_value !== 32'd0) begin
            errors++;
            $display("FAIL abort_result got %h/%h want f/0",
                     bus.argmax_output, bus.max_value);
        end
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 ||
            bus.score_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_flags got %b%b%b want 000",
                     bus.done, bus.busy, bus.score_ready);
        end
        tick();
        reset = 1'b0;
        tick();
        vec[0] = 32'd1;  vec[1] = 32'd2;  vec[2] = 32'd3;
        vec[3] = 32'd4;  vec[4] = 32'd5;  vec[5] = 32'd6;
        vec[6] = 32'd50; vec[7] = 32'd7;  vec[8] = 32'd8;
        vec[9] = 32'd9;
        pulse_start();
        stream(10);
        bus.score_valid = 1'b0;
        checks++;
        if (bus.argmax_output !== 4'd6 || bus.max_value !== 32'd50 ||
            bus.done !== 1'b1) begin
            errors++;
            $display("FAIL after_abort got %0d/%0d done=%b want 6/50 1",
                     bus.argmax_output, bus.max_value, bus.done);
        end
    endtask

`ifdef ARGMAX_TOP2_EN
    task automatic test_top2;
        load_basic();
        pulse_start();
        stream(10);
        bus.score_valid = 1'b0;
        checks++;
        if (bus.runner_up_idx !== 4'd9 || bus.margin !== 33'd1) begin
            errors++;
            $display("FAIL top2 got %0d/%0d want 9/1",
                     bus.runner_up_idx, bus.margin);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_min_ties();
        test_gaps_start();
        test_reset_mid();
`ifdef ARGMAX_TOP2_EN
        test_top2();
`endif
        checks++;
        if (timeouts !== 0) begin
            errors++;
            $display("FAIL handshake_timeout got %0d want 0", timeouts);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
